// File: rtl/qpow_seq.sv
// rtl/qpow_seq.sv - iterated-squaring sequencer, result = in^(2^k) over GF(2^233) via an external quad block
// Optional exponent reduction modulo 233 when QPOW_FROB_REDUCE_EN is defined.
module qpow_seq #(
    parameter int M    = 233,
    parameter int KW   = 8,
    parameter int STEP = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [M-1:0]  in,
    input  logic [KW-1:0] k,
    output logic          ready,
    output logic          done,
    output logic [M-1:0]  result,
    output logic          qb_en,
    output logic [M-1:0]  qb_in,
    output logic [3:0]    qb_sel,
    input  logic [M-1:0]  qb_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [M-1:0]  acc, acc_next;
    logic [KW-1:0] rem, rem_next;
    logic          done_next;
    logic [KW-1:0] k_eff;
    logic [KW-1:0] pass_pow;
    logic [KW-1:0] rem_after;

    // x^(2^233) = x, so exponents of 233 and above can be folded down once.
`ifdef QPOW_FROB_REDUCE_EN
    assign k_eff = (k >= KW'(233)) ? (k - KW'(233)) : k;
`else
    assign k_eff = k;
`endif

    // Pass power comes from registered rem only, keeping qb_sel free of input paths.
    assign pass_pow  = (rem > KW'(STEP)) ? KW'(STEP) : rem;
    assign rem_after = rem - pass_pow;

    assign ready  = (state == IDLE);
    assign qb_en  = (state == RUN);
    assign qb_sel = (state == RUN) ? pass_pow[3:0] : 4'd0;
    assign qb_in  = acc;
    assign result = acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            rem   <= rem_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        rem_next   = rem;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_next = in;
                    rem_next = k_eff;
                    if (k_eff == '0) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                acc_next = qb_out;
                rem_next = rem_after;
                if (rem_after == '0) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/qpow_seq.md
# qpow_seq

Iterated-squaring sequencer for GF(2^233): computes `result = in^(2^k)` for an exponent `k` of up to 255 by driving the buffered quad block through repeated passes. Each pass feeds the accumulator back with a power step of at most `STEP`. The block sits directly upstream of the buffered quad block and also consumes its output. It serves the Itoh-Tsujii inversion datapath and point-arithmetic squaring chains of the cryptoprocessor.

## Interface
Parameters:
- `M`, 233, field width in bits.
- `KW`, 8, exponent width.
- `STEP`, 14, maximum power per quad-block pass. Legal range 1..15, because it must fit `qb_sel`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request. Sampled only when `ready`=1.
- `in`  in  M  field element. Latched on an accepted `start`.
- `k`  in  KW  number of squarings. Latched on an accepted `start`.
- `ready`  out  1  high only in IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle.
- `result`  out  M  accumulator contents.
- `qb_en`  out  1  quad-block enable. High only in RUN.
- `qb_in`  out  M  equals the accumulator.
- `qb_sel`  out  4  power for this pass, `min(rem, STEP)`. Forced to 0 outside RUN.
- `qb_out`  in  M  quad-block result, `qb_in^(2^qb_sel)`. Combinational, same cycle.

## Operation
- Registers:
  - `acc` [M]
  - `rem` [KW]
  - `state` ∈ {IDLE, RUN, DONE}
  - `done`
- IDLE:
  - On `start`=1: `acc`←`in`, `rem`←`k'`, where `k'` is the effective exponent (see Configuration).
  - If `k'`=0, go to DONE. Otherwise go to RUN.
- RUN, each cycle:
  - `acc`←`qb_out`, `rem`←`rem − qb_sel`.
  - When the new `rem` is 0, go to DONE.
  - Pass count is n = ceil(k'/STEP). Every pass uses `qb_sel`=STEP except the last, which uses `k' − (n−1)·STEP`.
- DONE:
  - `done`=1 for exactly one cycle, then go to IDLE.
  - `start` is ignored in DONE.
- Ignored requests: `start` during RUN or DONE is dropped, not queued, and latched operands are unaffected. `in`/`k` changes outside an accepted start have no effect.
- `result` holds `acc` after `done` until the next accepted `start` overwrites it. In the accepting edge's next cycle, `result` shows the new `in`.
- No arithmetic is done locally. All field squaring comes through `qb_out`. `rem` never underflows because `qb_sel` ≤ `rem`.
- Reset (`rst_n`=0 at an edge), including mid-RUN, forces:
  - `state`=IDLE, `acc`=0, `rem`=0, `done`=0.
  - The partial result is discarded.

## Timing
- Reset values:
  - `ready`=1 (IDLE)
  - `done`=0
  - `result`=0
  - `qb_en`=0
  - `qb_in`=0
  - `qb_sel`=0
- Start accepted at edge E0:
  - RUN occupies cycles E0..E(n−1), with one quad-block pass per cycle.
  - `done` is high in the cycle after edge En. Latency from the start edge to `done` is n+1 cycles.
- k'=0: `done` is high in the cycle after E0 (latency 1) and `result`=`in`.
- Throughput: one request per n+2 cycles. The next `start` is accepted at the first IDLE edge after DONE.
- `qb_en`/`qb_sel` are decoded from registered state only, with no input-to-output combinational path. The `qb_out`→`acc` path is the critical path.

## Configuration
- `QPOW_FROB_REDUCE_EN` defined:
  - `k' = k mod 233`, implemented as `k ≥ 233 ? k − 233 : k` (valid for KW=8).
  - Correct because `x^(2^233)=x` in GF(2^233), so it saves up to 17 passes.
- Not defined:
  - `k' = k` with no reduction.
  - The result is mathematically identical and only the latency differs.

## Test plan
- Zero exponent: `in`=0x5A3 (low bits), `k`=0 → no `qb_en` pulse; `done` one cycle after the start edge; `result`=0x5A3.
- Single pass: `in`=x (bit 1), `k`=3 → one RUN cycle with `qb_sel`=3; `done` at latency 2; `result` has only bit 8 set.
- Multi-pass: `in`=x, `k`=30 → `qb_sel` sequence 14,14,2; `done` at latency 4; `result` equals the bench's quad-block model output for x^(2^30).
- Frobenius wrap: `in`=x, `k`=233.
  - With `QPOW_FROB_REDUCE_EN`: 0 passes, latency 1, `result`=x.
  - Without it: 17 passes (16×14 + 9), latency 18, `result`=x.
- Protocol: `start` with `k`=28 and `in`=1, then `start` again two cycles later with `k`=5 → the second request is ignored; `done` fires once, at latency 3; `result`=1.
- Reset mid-run: `k`=100, deassert `rst_n` at the 3rd RUN cycle → the next cycle shows `ready`=1, `result`=0, `done`=0, `qb_en`=0; no `done` pulse follows.
